operativo: RTL and testbench

Datapath (bloco operativo) responding to the `controle` FSM. It holds registers X, H and S and an ALU (add / multiply). It evaluates y = ((a·x) + b)·x + c in Horner order under the controller's mux/load strobes. It returns `pronto` when no multiply is outstanding, and flags the result with `valid` on `done`.

---
 rtl/operativo_pkg.sv | 18 +
 rtl/operativo_if.sv | 31 +++
 rtl/operativo_mult_seq.sv | 78 +++++++
 rtl/operativo.sv | 146 ++++++++++++++
 tb/tb_operativo.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/operativo_pkg.sv
// Shared encodings for the operativo datapath: mux selects, ALU op codes and
// the state type of the sequential multiplier.
package operativo_pkg;

  localparam logic [1:0] M0_X  = 2'b01;
  localparam logic [1:0] M1_X  = 2'b01;
  localparam logic [1:0] M2_A  = 2'b00;
  localparam logic [1:0] M2_BC = 2'b11;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_RUN  = 1'b1
  } mult_state_e;

endpackage

// File: rtl/operativo_if.sv
// Controller-to-datapath bundle: operands, mux/load strobes and the status
// returned to the controller.
interface operativo_if #(parameter int W = 8);

  logic [W-1:0]   x_in;
  logic [W-1:0]   coef_a;
  logic [W-1:0]   coef_b;
  logic [W-1:0]   coef_c;
  logic           lx;
  logic [1:0]     m0;
  logic [1:0]     m1;
  logic [1:0]     m2;
  logic           h;
  logic           lh;
  logic           ls;
  logic           done;
  logic           pronto;
  logic [2*W-1:0] s_out;
  logic           valid;

  modport master (
    output x_in, coef_a, coef_b, coef_c, lx, m0, m1, m2, h, lh, ls, done,
    input  pronto, s_out, valid
  );

  modport slave (
    input  x_in, coef_a, coef_b, coef_c, lx, m0, m1, m2, h, lh, ls, done,
    output pronto, s_out, valid
  );

endinterface

// File: rtl/operativo_mult_seq.sv
// Shift-add multiplier: bit 0 is consumed in the start cycle, the remaining
// W-1 bits in the busy cycles; fin flags the cycle whose p is the product.
module mult_seq
  import operativo_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           ck,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic [2*W-1:0] p,
  output logic           fin
);

  localparam int CW = $clog2(W);

  mult_state_e    state_q, state_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_next;

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      MS_IDLE: begin
        if (start) begin
          acc_d    = b[0] ? a : '0;
          mcand_d  = a << 1;
          mplier_d = b >> 1;
          cnt_d    = CW'(W - 1);
          state_d  = MS_RUN;
        end
      end
      MS_RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    // NOTE: sequential state is updated with <= only, so every flop samples
    // the values from before the edge.
    if (!rst) begin
      state_q  <= MS_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == MS_RUN);
  assign fin  = busy && (cnt_q == CW'(1));
  assign p    = acc_next;

endmodule

// File: rtl/operativo.sv
// Horner datapath for y = ((a*x)+b)*x+c driven by the controle FSM strobes.
// Define MULT_SEQ_EN for the multi-cycle shift-add multiplier.
module operativo
  import operativo_pkg::*;
#(
  parameter int W = 8
) (
  input  logic ck,
  input  logic rst,
  operativo_if.slave bus
);

  localparam int W2 = 2 * W;

  logic [W-1:0]  x_q, x_d;
  logic [W2-1:0] h_q, h_d;
  logic [W2-1:0] s_q, s_d;
  logic          add_idx_q, add_idx_d;
  logic          valid_q, valid_d;
  logic [W2-1:0] op_a, op_b, sum;
  logic          commit_add;

  always_comb begin
    op_a = (bus.m0 == M0_X) ? {{W{1'b0}}, x_q} : h_q;
    op_b = '0;
    if (bus.m1 == M1_X) begin
      op_b[W-1:0] = x_q;
    end else begin
      case (bus.m2)
        M2_A:    op_b[W-1:0] = bus.coef_a;
        M2_BC:   op_b[W-1:0] = add_idx_q ? bus.coef_c : bus.coef_b;
        default: op_b        = '0;
      endcase
    end
    sum = op_a + op_b;
  end

  assign commit_add = (bus.h == OP_ADD) && (bus.lh || bus.ls);

`ifdef MULT_SEQ_EN
  logic          start, busy, fin;
  logic          armed_q, armed_d;
  logic          pend_h_q, pend_h_d;
  logic          pend_s_q, pend_s_d;
  logic          take_h, take_s;
  logic [W2-1:0] mult_p;

  // lx blocks the start so the multiply sees the freshly loaded X.
  assign start = (bus.h == OP_MUL) && !bus.lx && !armed_q && !busy;

  mult_seq #(.W(W)) u_mult (
    .ck    (ck),
    .rst   (rst),
    .start (start),
    .a     (op_a),
    .b     (op_b[W-1:0]),
    .busy  (busy),
    .p     (mult_p),
    .fin   (fin)
  );

  always_comb begin
    armed_d  = armed_q;
    pend_h_d = pend_h_q;
    pend_s_d = pend_s_q;
    take_h   = pend_h_q || ((bus.h == OP_MUL) && bus.lh);
    take_s   = pend_s_q || ((bus.h == OP_MUL) && bus.ls);
    h_d      = h_q;
    s_d      = s_q;
    if (bus.h == OP_ADD) armed_d = 1'b0;
    else if (start)      armed_d = 1'b1;
    if (fin) begin
      pend_h_d = 1'b0;
      pend_s_d = 1'b0;
    end else if ((bus.h == OP_MUL) && (busy || start)) begin
      pend_h_d = pend_h_q || bus.lh;
      pend_s_d = pend_s_q || bus.ls;
    end
    // An add committed while busy is overwritten by a pending product.
    if (commit_add && bus.lh) h_d = sum;
    if (commit_add && bus.ls) s_d = sum;
    if (fin && take_h) h_d = mult_p;
    if (fin && take_s) s_d = mult_p;
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      armed_q  <= 1'b0;
      pend_h_q <= 1'b0;
      pend_s_q <= 1'b0;
    end else begin
      armed_q  <= armed_d;
      pend_h_q <= pend_h_d;
      pend_s_q <= pend_s_d;
    end
  end

  assign bus.pronto = !busy && !pend_h_q && !pend_s_q;
`else
  logic [W2-1:0] prod, alu;

  assign prod = op_a * op_b;
  assign alu  = (bus.h == OP_MUL) ? prod : sum;

  always_comb begin
    h_d = h_q;
    s_d = s_q;
    if (bus.lh) h_d = alu;
    if (bus.ls) s_d = alu;
  end

  assign bus.pronto = 1'b1;
`endif

  always_comb begin
    x_d       = x_q;
    add_idx_d = add_idx_q;
    valid_d   = bus.done;
    if (bus.lx) begin
      x_d       = bus.x_in;
      add_idx_d = 1'b0;
    end else if (commit_add) begin
      add_idx_d = !add_idx_q;
    end
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      x_q       <= '0;
      h_q       <= '0;
      s_q       <= '0;
      add_idx_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      x_q       <= x_d;
      h_q       <= h_d;
      s_q       <= s_d;
      add_idx_q <= add_idx_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.s_out = s_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_operativo.sv
// Directed bench for operativo: expected H/S pushed when an operation is
// driven, popped and compared once pronto shows the result is committed.
module tb_operativo;

  localparam int W = 8;

  typedef struct {
    string       tag;
    logic [15:0] h;
    logic [15:0] s;
  } exp_t;

  logic ck;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  operativo_if #(.W(W)) bus ();

  operativo #(.W(W)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    @(negedge ck);
  endtask

  task automatic wait_pronto(input string tag);
    int n = 0;
    while (bus.pronto !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_pronto"}, 32'(bus.pronto), 32'd1);
  endtask

  task automatic sb_push(input string tag, input logic [15:0] eh, input logic [15:0] es);
    exp_t e;
    e.tag = tag;
    e.h   = eh;
    e.s   = es;
    sb.push_back(e);
  endtask

  task automatic sb_pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_h"}, 32'(dut.h_q), 32'(e.h));
      check({e.tag, "_s"}, 32'(bus.s_out), 32'(e.s));
    end
  endtask

  task automatic load_x(input logic [7:0] x);
    bus.x_in = x;
    bus.lx   = 1'b1;
    tick();
    bus.lx   = 1'b0;
  endtask

  task automatic op(input string tag, input logic hh, input logic [1:0] s0, input logic [1:0] s1,
                    input logic [1:0] s2, input logic l_h, input logic l_s,
                    input logic [15:0] eh, input logic [15:0] es);
    sb_push(tag, eh, es);
    bus.h  = hh;
    bus.m0 = s0;
    bus.m1 = s1;
    bus.m2 = s2;
    bus.lh = l_h;
    bus.ls = l_s;
    tick();
    bus.h  = 1'b0;
    bus.lh = 1'b0;
    bus.ls = 1'b0;
    wait_pronto(tag);
    sb_pop_check();
  endtask

  initial begin
    rst        = 1'b0;
    bus.x_in   = '0;
    bus.coef_a = 8'd2;
    bus.coef_b = 8'd5;
    bus.coef_c = 8'd7;
    bus.lx     = 1'b0;
    bus.m0     = 2'b00;
    bus.m1     = 2'b00;
    bus.m2     = 2'b00;
    bus.h      = 1'b0;
    bus.lh     = 1'b0;
    bus.ls     = 1'b0;
    bus.done   = 1'b0;
    tick();
    tick();
    check("rst_h", 32'(dut.h_q), 32'd0);
    check("rst_s", 32'(bus.s_out), 32'd0);
    check("rst_pronto", 32'(bus.pronto), 32'd1);
    check("rst_valid", 32'(bus.valid), 32'd0);
    rst = 1'b1;

    // Full Horner sequence, x=3 a=2 b=5 c=7.
    load_x(8'd3);
    op("c1_ax",   1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 16'd6,  16'd0);
    op("c1_axb",  1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0, 16'd11, 16'd0);
    op("c1_axbx", 1'b1, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 16'd33, 16'd0);
    op("c1_y",    1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1, 16'd33, 16'd40);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("c1_valid_pulse", 32'(bus.valid), 32'd1);
    check("c1_s_hold", 32'(bus.s_out), 32'd40);
    tick();
    check("c1_valid_end", 32'(bus.valid), 32'd0);

    // Multiply with lh in the start cycle; watch pronto across the run.
    sb_push("c2", 16'd6, 16'd40);
    bus.h  = 1'b1;
    bus.lh = 1'b1;
    bus.m0 = 2'b01;
    bus.m1 = 2'b00;
    bus.m2 = 2'b00;
    tick();
    bus.h  = 1'b0;
    bus.lh = 1'b0;
`ifdef MULT_SEQ_EN
    check("c2_h_before", 32'(dut.h_q), 32'd33);
    for (int i = 1; i < W; i++) begin
      check($sformatf("c2_busy_t%0d", i), 32'(bus.pronto), 32'd0);
      tick();
    end
    check("c2_pronto_tW", 32'(bus.pronto), 32'd1);
`endif
    wait_pronto("c2");
    sb_pop_check();

    // Reset in cycle t+3 of a multiply (X*X = 9).
    bus.h  = 1'b1;
    bus.lh = 1'b1;
    bus.m0 = 2'b01;
    bus.m1 = 2'b01;
    tick();
    bus.h  = 1'b0;
    bus.lh = 1'b0;
    bus.m1 = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("c5_h", 32'(dut.h_q), 32'd0);
    check("c5_x", 32'(dut.x_q), 32'd0);
    check("c5_s", 32'(bus.s_out), 32'd0);
    check("c5_pronto", 32'(bus.pronto), 32'd1);
    rst = 1'b1;
    repeat (W + 2) tick();
    check("c5_h_late", 32'(dut.h_q), 32'd0);
    check("c5_pronto_late", 32'(bus.pronto), 32'd1);

    // lh+ls together on an add with coef_b selected.
    load_x(8'd11);
    op("c3_h11",  1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 16'd11, 16'd0);
    op("c3_idx0", 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 16'd11, 16'd0);
    op("c3_both", 1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 16'd16, 16'd16);

    // Wrap-around of add and truncation of multiply.
    load_x(8'hFF);
    bus.coef_a = 8'hFF;
    op("c4_fe01", 1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 16'hFE01, 16'd16);
    op("c4_ff00", 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 16'hFF00, 16'd16);
    op("c4_ffff", 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 16'hFFFF, 16'd16);
    bus.coef_a = 8'd1;
    op("c4_addwrap", 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 16'h0000, 16'd16);
    load_x(8'h80);
    bus.coef_a = 8'h80;
    op("c4_4000", 1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 16'h4000, 16'd16);
    bus.coef_a = 8'd2;
    op("c4_8000", 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 16'h8000, 16'd16);
    op("c4_mulwrap", 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 16'h0000, 16'd16);

    // lx with h=1 defers the multiply to the new X.
    load_x(8'd3);
    sb_push("c6", 16'd18, 16'd16);
    bus.x_in = 8'd9;
    bus.lx   = 1'b1;
    bus.h    = 1'b1;
    bus.lh   = 1'b1;
    bus.m0   = 2'b01;
    bus.m1   = 2'b00;
    bus.m2   = 2'b00;
    tick();
    bus.lx   = 1'b0;
    tick();
    bus.h    = 1'b0;
    bus.lh   = 1'b0;
    wait_pronto("c6");
    sb_pop_check();
    check("c6_x", 32'(dut.x_q), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
